// File: rtl/y86_stage_reg.sv
// Y86-64 pipeline stage register: bubble/stall control, optional freeze on a
// captured exception, sticky stall/bubble conflict flag and saturating event counters.
module y86_stage_reg #(
  parameter int unsigned          WORD_W        = 64,
  parameter int unsigned          STAT_W        = 3,
  parameter logic [3:0]           BUBBLE_ICODE  = 4'h1,
  parameter logic [STAT_W-1:0]    BUBBLE_STAT   = STAT_W'(1),
  parameter bit                   FREEZE_ON_EXC = 1'b0,
  parameter int unsigned          CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_stall,
  input  logic              in_bubble,
  input  logic              in_valid,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valP,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [STAT_W-1:0] out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [3:0]        out_rA,
  output logic [3:0]        out_rB,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valP,
  output logic              frozen,
  output logic              conflict,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(1);
  localparam logic [3:0]        RNONE    = 4'hF;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic              valid_q;
  logic [STAT_W-1:0] stat_q;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
  logic [WORD_W-1:0] valc_q, valp_q;
  logic              frozen_q, frozen_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic take_bubble, take_stall, take_load;

  // A frozen register ignores stall/bubble entirely, so none of the paths fire.
  assign take_bubble = !frozen_q && in_bubble;
  assign take_stall  = !frozen_q && in_stall && !in_bubble;
  assign take_load   = !frozen_q && !in_stall && !in_bubble;

  always_comb begin
    frozen_d     = frozen_q;
    conflict_d   = conflict_q | (!frozen_q && in_stall && in_bubble);
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FREEZE_ON_EXC && take_load && in_valid && (in_stat != STAT_AOK))
      frozen_d = 1'b1;
    if (!frozen_q) begin
      if (cnt_clr) begin
        stall_cnt_d  = '0;
        bubble_cnt_d = '0;
      end else begin
        if (take_stall && (stall_cnt_q != CNT_MAX))
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (take_bubble && (bubble_cnt_q != CNT_MAX))
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      stat_q       <= BUBBLE_STAT;
      icode_q      <= BUBBLE_ICODE;
      ifun_q       <= 4'h0;
      ra_q         <= RNONE;
      rb_q         <= RNONE;
      valc_q       <= '0;
      valp_q       <= '0;
      frozen_q     <= 1'b0;
      conflict_q   <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      frozen_q     <= frozen_d;
      conflict_q   <= conflict_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      if (take_bubble) begin
        valid_q <= 1'b0;
        stat_q  <= BUBBLE_STAT;
        icode_q <= BUBBLE_ICODE;
        ifun_q  <= 4'h0;
        ra_q    <= RNONE;
        rb_q    <= RNONE;
        valc_q  <= '0;
        valp_q  <= '0;
      end else if (take_load) begin
        valid_q <= in_valid;
        stat_q  <= in_stat;
        icode_q <= in_icode;
        ifun_q  <= in_ifun;
        ra_q    <= in_rA;
        rb_q    <= in_rB;
        valc_q  <= in_valC;
        valp_q  <= in_valP;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_stat   = stat_q;
  assign out_icode  = icode_q;
  assign out_ifun   = ifun_q;
  assign out_rA     = ra_q;
  assign out_rB     = rb_q;
  assign out_valC   = valc_q;
  assign out_valP   = valp_q;
  assign frozen     = frozen_q;
  assign conflict   = conflict_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_y86_stage_reg.sv
// Directed bench for y86_stage_reg: one freezing instance with 4-bit counters and
// one default instance sharing the same stimulus.
module tb_y86_stage_reg;

  logic        clk = 1'b0;
  logic        reset, in_stall, in_bubble, in_valid, cnt_clr;
  logic [2:0]  in_stat;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC, in_valP;

  logic        out_valid, frozen, conflict;
  logic [2:0]  out_stat;
  logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
  logic [63:0] out_valC, out_valP;
  logic [3:0]  stall_cnt, bubble_cnt;

  logic        d0_valid, d0_frozen, d0_conflict;
  logic [2:0]  d0_stat;
  logic [3:0]  d0_icode, d0_ifun, d0_rA, d0_rB;
  logic [63:0] d0_valC, d0_valP;
  logic [15:0] d0_stall_cnt, d0_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y86_stage_reg #(.FREEZE_ON_EXC(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .in_stall(in_stall), .in_bubble(in_bubble),
    .in_valid(in_valid), .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_valP(in_valP),
    .cnt_clr(cnt_clr), .out_valid(out_valid), .out_stat(out_stat),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
    .out_valC(out_valC), .out_valP(out_valP), .frozen(frozen), .conflict(conflict),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  y86_stage_reg u_dflt (
    .clk(clk), .reset(reset), .in_stall(in_stall), .in_bubble(in_bubble),
    .in_valid(in_valid), .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_valP(in_valP),
    .cnt_clr(cnt_clr), .out_valid(d0_valid), .out_stat(d0_stat),
    .out_icode(d0_icode), .out_ifun(d0_ifun), .out_rA(d0_rA), .out_rB(d0_rB),
    .out_valC(d0_valC), .out_valP(d0_valP), .frozen(d0_frozen), .conflict(d0_conflict),
    .stall_cnt(d0_stall_cnt), .bubble_cnt(d0_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    in_valid = v; in_stat = st; in_icode = ic; in_ifun = fn;
    in_rA = ra; in_rB = rb; in_valC = vc; in_valP = vp;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_icode"}, 64'(out_icode), 64'h1);
    chk({tag, "_ifun"},  64'(out_ifun),  64'h0);
    chk({tag, "_rA"},    64'(out_rA),    64'hF);
    chk({tag, "_rB"},    64'(out_rB),    64'hF);
    chk({tag, "_valC"},  out_valC,       64'h0);
    chk({tag, "_valP"},  out_valP,       64'h0);
    chk({tag, "_stat"},  64'(out_stat),  64'h1);
    chk({tag, "_valid"}, 64'(out_valid), 64'h0);
  endtask

  initial begin
    reset = 1'b1; in_stall = 1'b0; in_bubble = 1'b0; cnt_clr = 1'b0;
    drive(1'b1, 3'd1, 4'h9, 4'h9, 4'h9, 4'h9, 64'hDEAD, 64'hBEEF);
    tick();
    reset = 1'b0;
    chk_bubble("rst");
    chk("rst_stall_cnt",  64'(stall_cnt),  64'd0);
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("rst_frozen",     64'(frozen),     64'd0);
    chk("rst_conflict",   64'(conflict),   64'd0);

    // Normal flow, including a check that nothing leaks through before the edge
    drive(1'b1, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h1234, 64'h0A);
    #2;
    chk("no_comb_path_icode", 64'(out_icode), 64'h1);
    tick();
    chk("load1_icode", 64'(out_icode), 64'h6);
    chk("load1_rA",    64'(out_rA),    64'h2);
    chk("load1_rB",    64'(out_rB),    64'h3);
    chk("load1_valC",  out_valC,       64'h1234);
    chk("load1_valP",  out_valP,       64'h0A);
    chk("load1_valid", 64'(out_valid), 64'h1);
    chk("load1_stat",  64'(out_stat),  64'h1);
    drive(1'b1, 3'd1, 4'h3, 4'h0, 4'hF, 4'h4, 64'h100, 64'h14);
    tick();
    chk("load2_icode", 64'(out_icode), 64'h3);
    chk("load2_valC",  out_valC,       64'h100);
    chk("load2_rA",    64'(out_rA),    64'hF);

    // Stall for three cycles while inputs keep changing
    in_stall = 1'b1;
    drive(1'b1, 3'd1, 4'h7, 4'h1, 4'h5, 4'h6, 64'h55, 64'h1E);
    tick();
    drive(1'b1, 3'd1, 4'h8, 4'h2, 4'h1, 4'h1, 64'h66, 64'h28);
    tick();
    drive(1'b1, 3'd1, 4'h7, 4'h1, 4'h5, 4'h6, 64'h55, 64'h1E);
    tick();
    chk("stall_icode", 64'(out_icode), 64'h3);
    chk("stall_valC",  out_valC,       64'h100);
    chk("stall_valP",  out_valP,       64'h14);
    chk("stall_cnt3",  64'(stall_cnt), 64'd3);
    in_stall = 1'b0;
    tick();
    chk("unstall_icode", 64'(out_icode), 64'h7);
    chk("unstall_ifun",  64'(out_ifun),  64'h1);
    chk("unstall_valC",  out_valC,       64'h55);
    chk("unstall_cnt",   64'(stall_cnt), 64'd3);

    // Bubble alone, then stall and bubble together
    in_bubble = 1'b1;
    tick();
    in_bubble = 1'b0;
    chk_bubble("bub1");
    chk("bub1_cnt",      64'(bubble_cnt), 64'd1);
    chk("bub1_conflict", 64'(conflict),   64'd0);
    drive(1'b1, 3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h32);
    tick();
    chk("reload_icode", 64'(out_icode), 64'h2);
    in_stall = 1'b1; in_bubble = 1'b1;
    tick();
    in_stall = 1'b0; in_bubble = 1'b0;
    chk_bubble("bub2");
    chk("bub2_cnt",       64'(bubble_cnt), 64'd2);
    chk("bub2_stall_cnt", 64'(stall_cnt),  64'd3);
    chk("bub2_conflict",  64'(conflict),   64'd1);
    drive(1'b1, 3'd1, 4'h6, 4'h1, 4'h3, 4'h4, 64'h77, 64'h3C);
    tick();
    chk("conflict_sticky", 64'(conflict),  64'd1);
    chk("after_bub_icode", 64'(out_icode), 64'h6);

    // Saturation: 3 + 20 stalls clamps a 4-bit counter at 15
    in_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd1, 4'(i), 4'h0, 4'h0, 4'h0, 64'(i), 64'(i));
      tick();
    end
    chk("sat_stall_cnt",   64'(stall_cnt),    64'd15);
    chk("wide_stall_cnt",  64'(d0_stall_cnt), 64'd23);
    chk("sat_data_held",   out_valC,          64'h77);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_stall_cnt",  64'(stall_cnt),  64'd0);
    chk("clr_bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("clr_data_icode", 64'(out_icode),  64'h6);
    chk("clr_data_valC",  out_valC,        64'h77);
    chk("clr_conflict",   64'(conflict),   64'd1);
    tick();
    in_stall = 1'b0;
    chk("post_clr_stall", 64'(stall_cnt), 64'd1);

    // Freeze on a captured HLT
    drive(1'b1, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h40);
    tick();
    chk("hlt_stat",    64'(out_stat),  64'd2);
    chk("hlt_frozen",  64'(frozen),    64'd1);
    chk("dflt_frozen", 64'(d0_frozen), 64'd0);
    drive(1'b1, 3'd1, 4'h6, 4'h0, 4'h1, 4'h1, 64'h99, 64'h50);
    in_bubble = 1'b1;
    tick();
    in_stall = 1'b1;
    tick();
    in_stall = 1'b0; in_bubble = 1'b0;
    tick();
    chk("frz_icode",      64'(out_icode),  64'h0);
    chk("frz_stat",       64'(out_stat),   64'd2);
    chk("frz_valid",      64'(out_valid),  64'd1);
    chk("frz_valP",       out_valP,        64'h40);
    chk("frz_bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("frz_stall_cnt",  64'(stall_cnt),  64'd1);
    chk("dflt_loads",     64'(d0_icode),   64'h6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bubble("frz_rst");
    chk("frz_rst_frozen",   64'(frozen),   64'd0);
    chk("frz_rst_conflict", 64'(conflict), 64'd0);
    chk("frz_rst_stall",    64'(stall_cnt), 64'd0);

    // A non-AOK status only freezes when the instruction is valid
    drive(1'b0, 3'd3, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8, 64'h60);
    tick();
    chk("inv_adr_frozen", 64'(frozen),   64'd0);
    chk("inv_adr_stat",   64'(out_stat), 64'd3);
    drive(1'b1, 3'd4, 4'hC, 4'h0, 4'h1, 4'h2, 64'h9, 64'h70);
    tick();
    chk("ins_frozen", 64'(frozen),    64'd1);
    chk("ins_icode",  64'(out_icode), 64'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_stage_reg.md
Name: y86_stage_reg

Overview:
- Parametrised pipeline register for the Y86-64 pipeline. One instance sits at each stage boundary: F->D, D->E, E->M and M->W.
- Carries the instruction fields icode, ifun, rA, rB, valC and valP, plus a status code and a valid bit.
- Supports stall and bubble controls with a defined priority.
- Adds three behaviours: synchronous reset to a bubble, an optional freeze once an exception status is captured, and saturating stall/bubble event counters for pipeline performance analysis.

Parameters:
- WORD_W, 64, width of valC and valP.
- STAT_W, 3, width of the status code. Encodings: AOK=1, HLT=2, ADR=3, INS=4.
- BUBBLE_ICODE, 4'h1, icode inserted on a bubble (nop).
- BUBBLE_STAT, 1, status inserted on a bubble (AOK).
- FREEZE_ON_EXC, 0. When 1, the register holds its contents once a non-AOK status has been captured.
- CNT_W, 16, width of each event counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_stall, input, 1, hold current contents.
- in_bubble, input, 1, load a nop bubble.
- in_valid, input, 1, upstream stage holds a real instruction.
- in_stat, input, STAT_W, upstream status.
- in_icode, input, 4, upstream icode.
- in_ifun, input, 4, upstream ifun.
- in_rA, input, 4, upstream rA.
- in_rB, input, 4, upstream rB.
- in_valC, input, WORD_W, upstream valC.
- in_valP, input, WORD_W, upstream valP.
- cnt_clr, input, 1, synchronous clear of the counters only.
- out_valid, out_stat, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP: outputs with the same widths as the matching inputs, registered stage contents.
- frozen, output, 1, register is locked on an exception (FREEZE_ON_EXC=1 only).
- conflict, output, 1, sticky flag: in_stall and in_bubble were asserted in the same cycle.
- stall_cnt, output, CNT_W, saturating count of stall cycles.
- bubble_cnt, output, CNT_W, saturating count of bubble cycles.

Behaviour:
- Reset value (reset=1 at a rising edge), and the contents of every bubble load:
  - out_icode=BUBBLE_ICODE, out_ifun=0, out_rA=4'hF, out_rB=4'hF (RNONE), out_valC=0, out_valP=0.
  - out_stat=BUBBLE_STAT, out_valid=0.
- Reset also clears frozen, conflict, stall_cnt and bubble_cnt. Reset overrides every other input, including a frozen state and an in-progress stall.
- Priority each rising edge, highest first:
  - reset.
  - frozen: hold all fields; counters do not change.
  - in_bubble=1: load the bubble.
  - in_stall=1: hold all fields.
  - Otherwise: load all in_* fields.
- Latency: one cycle. An input presented at edge N appears on the outputs after edge N.
- in_stall and in_bubble both high:
  - The bubble wins.
  - conflict is set to 1 and stays set until reset.
  - bubble_cnt increments; stall_cnt does not.
- FREEZE_ON_EXC=1:
  - Whenever a load (normal, not bubble) captures in_stat != AOK with in_valid=1, frozen is set from the next cycle onward.
  - While frozen, stall and bubble are ignored and the outputs keep the faulting instruction.
  - Only reset clears frozen.
- FREEZE_ON_EXC=0: frozen is tied to 0.
- Counters:
  - stall_cnt increments on each non-frozen, non-reset edge where the stall path is taken.
  - bubble_cnt increments on each edge where the bubble path is taken.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 zeroes both counters on that edge. A simultaneous increment is dropped, so the result is 0.
  - cnt_clr does not affect the data fields, frozen or conflict.
- Fields are sampled only at the rising edge. There is no combinational path from any input to any output.
- Arithmetic: counters use unsigned CNT_W-bit addition with a saturation compare. No other arithmetic.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset for 1 cycle.
  - Required: out_icode=1, out_rA=F, out_rB=F, out_stat=1, out_valid=0, stall_cnt=0, bubble_cnt=0.
- Normal flow:
  - Stimulus: drive icode=6, ifun=0, rA=2, rB=3, valC=0x1234, valP=0x0A, valid=1, stat=1.
  - Required: the values appear after exactly 1 edge. A new value presented every cycle follows with a 1-cycle lag.
- Stall:
  - Stimulus: hold in_stall=1 for 3 cycles while the inputs change.
  - Required: outputs unchanged, stall_cnt=3. Deasserting the stall loads the current inputs on the next edge.
- Bubble and conflict:
  - Stimulus: in_bubble=1 for 1 cycle; later, in_stall=1 and in_bubble=1 together.
  - Required: both edges load a nop (icode=1, valid=0), bubble_cnt=2, conflict=1 and it stays 1 until reset.
- Freeze (FREEZE_ON_EXC=1):
  - Stimulus: load stat=2 (HLT), icode=0, valid=1; then drive new inputs and a bubble.
  - Required: frozen=1 and the outputs stay at the HLT instruction. Reset restores the bubble values and frozen=0.
- Saturation and clear (CNT_W=4):
  - Stimulus: 20 stall cycles.
  - Required: stall_cnt=15. cnt_clr concurrent with a stall gives stall_cnt=0, and the data fields are unaffected.
